motion_scheduler: RTL and testbench

- Sequences the on-screen circle's position for the pattern generator. It turns raw board buttons into synchronized, debounced, arbitrated step commands.
- Position updates are applied only at the frame boundary, so no frame tears.
- Handles boundary clamping, acceleration on held buttons, and a timed recenter/freeze after a collision.
- Sits between the board buttons and the pixel/color generator, which consumes pos_h and pos_v as the circle center.

---
 rtl/motion_pkg.sv | 50 +++++
 rtl/motion_scheduler_btn_debounce.sv | 42 ++++
 rtl/motion_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_motion_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// motion_pkg -- shared types and screen constants for the motion path.
// Used by motion_scheduler, btn_debounce, the pixel generator and the
// collision checker so all of them agree on screen size and circle radius.
//   mstate_t   : scheduler FSM state (IDLE / RUN / RECENTER)
//   dir_t      : signed 2-bit direction (-1, 0, +1)
//   dir_pair_t : resolved horizontal + vertical direction
package motion_pkg;

  localparam int SCR_HD    = 1920;
  localparam int SCR_VD    = 1080;
  localparam int SCR_R     = 100;
  localparam int SCR_CTR_H = SCR_HD / 2;
  localparam int SCR_CTR_V = SCR_VD / 2;

  // button lane order inside the scheduler
  localparam int NUM_BTN = 4;
  localparam int BTN_U   = 0;
  localparam int BTN_D   = 1;
  localparam int BTN_L   = 2;
  localparam int BTN_R   = 3;

  typedef logic [1:0] mstate_t;
  localparam mstate_t ST_IDLE     = 2'd0;
  localparam mstate_t ST_RUN      = 2'd1;
  localparam mstate_t ST_RECENTER = 2'd2;

  typedef logic signed [1:0] dir_t;

  typedef struct packed {
    dir_t h;
    dir_t v;
  } dir_pair_t;

  // neg only -> -1, pos only -> +1, both or neither -> 0
  function automatic dir_t resolve(input logic neg, input logic pos);
    if (neg && !pos) return -2'sd1;
    if (pos && !neg) return 2'sd1;
    return 2'sd0;
  endfunction

  // clamp in 13-bit signed so under/overflow is caught before truncation
  function automatic logic [11:0] clamp_pos(input logic signed [12:0] v,
                                            input logic signed [12:0] lo,
                                            input logic signed [12:0] hi);
    if (v < lo) return lo[11:0];
    if (v > hi) return hi[11:0];
    return v[11:0];
  endfunction

endpackage

// File: rtl/motion_scheduler_btn_debounce.sv
// btn_debounce -- 2-flop synchronizer plus stable-count filter for one
// raw button. The accepted level flips only after DEB_CYCLES consecutive
// synchronized samples that differ from it; any agreeing sample restarts
// the count.
//   clk_148MHz : pixel clock
//   reset      : async active-high reset (level clears to 0)
//   btn        : raw asynchronous button
//   level      : accepted (debounced) level
module btn_debounce #(
  parameter int DEB_CYCLES = 1480000
) (
  input  logic clk_148MHz,
  input  logic reset,
  input  logic btn,
  output logic level
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_148MHz or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        // this is the DEB_CYCLES-th differing sample in a row
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/motion_scheduler.sv
// motion_scheduler -- turns board buttons into frame-synchronous moves of
// the circle center consumed by the pixel/color generator.
//   clk_148MHz, reset (async, active-high)
//   enable             : motion enable; low forces IDLE
//   btnU/btnD/btnL/btnR: raw asynchronous buttons
//   frame_tick         : one-cycle pulse at start of vertical blanking
//   collision          : flag from the collision checker
//   pos_h, pos_v       : circle center (12 bits each)
//   step               : step size in use, 0 when no direction active
//   moving             : RUN with a nonzero resolved direction
//   frozen             : RECENTER in progress
// Build option: define MOTION_DIAG_EN to step both axes on the same frame;
// otherwise a both-axes request alternates H/V one frame at a time.
module motion_scheduler
  import motion_pkg::*;
#(
  parameter int HD              = SCR_HD,
  parameter int VD              = SCR_VD,
  parameter int R               = SCR_R,
  parameter int DEB_CYCLES      = 1480000,
  parameter int RAMP_FRAMES     = 30,
  parameter int MAX_STEP        = 4,
  parameter int RECENTER_FRAMES = 60
) (
  input  logic        clk_148MHz,
  input  logic        reset,
  input  logic        enable,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        frame_tick,
  input  logic        collision,
  output logic [11:0] pos_h,
  output logic [11:0] pos_v,
  output logic [2:0]  step,
  output logic        moving,
  output logic        frozen
);

  localparam int HOLD_MAX = 2 * RAMP_FRAMES;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam int RCW      = (RECENTER_FRAMES < 1) ? 1 : $clog2(RECENTER_FRAMES + 1);

  localparam logic [11:0]        RST_H = 12'(HD / 2);
  localparam logic [11:0]        RST_V = 12'(VD / 2);
  localparam logic signed [12:0] LO    = 13'(R + 1);
  localparam logic signed [12:0] HI_H  = 13'(HD - R - 1);
  localparam logic signed [12:0] HI_V  = 13'(VD - R - 1);

  // ---------------- buttons ----------------
  logic [NUM_BTN-1:0] btn_raw, btn_lvl;

  assign btn_raw = {btnR, btnL, btnD, btnU};

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_BTN-1:0] (
    .clk_148MHz (clk_148MHz),
    .reset      (reset),
    .btn        (btn_raw),
    .level      (btn_lvl)
  );

  dir_t      dh, dv;
  dir_pair_t dir_cur, dir_q;
  logic      dir_any, dir_chg;

  assign dh      = resolve(btn_lvl[BTN_L], btn_lvl[BTN_R]);
  assign dv      = resolve(btn_lvl[BTN_U], btn_lvl[BTN_D]);
  assign dir_cur = '{h: dh, v: dv};
  assign dir_any = (dh != 2'sd0) || (dv != 2'sd0);
  assign dir_chg = (dir_cur != dir_q);

  // ---------------- state ----------------
  mstate_t        st;
  logic [HW-1:0]  hold;
  logic [RCW-1:0] rc;
  logic [2:0]     step_cur;
  logic [11:0]    nxt_h, nxt_v;
  logic           mv_h, mv_v;
  logic           run_tick;

  assign run_tick = enable && (st == ST_RUN) && frame_tick && !collision;

  // hold only grows while the same nonzero direction set persists in RUN;
  // IDLE and RECENTER keep it cleared so motion restarts at step 1
  always_ff @(posedge clk_148MHz or posedge reset) begin
    if (reset) begin
      dir_q <= '0;
      hold  <= '0;
    end else begin
      dir_q <= dir_cur;
      if (st != ST_RUN || !dir_any || dir_chg)
        hold <= '0;
      else if (frame_tick && hold != HW'(HOLD_MAX))
        hold <= hold + 1'b1;
    end
  end

  always_comb begin
    if (int'(hold) < RAMP_FRAMES)          step_cur = 3'd1;
    else if (int'(hold) < 2 * RAMP_FRAMES) step_cur = 3'd2;
    else                                   step_cur = 3'(MAX_STEP);
  end

  assign moving = (st == ST_RUN) && dir_any;
  assign step   = moving ? step_cur : 3'd0;
  assign frozen = (st == ST_RECENTER);

  // ---------------- axis arbitration ----------------
`ifdef MOTION_DIAG_EN
  always_comb begin
    mv_h = (dh != 2'sd0);
    mv_v = (dv != 2'sd0);
  end
`else
  logic ptr_v;   // 0: horizontal gets the next shared frame
  logic both;

  always_comb begin
    both = (dh != 2'sd0) && (dv != 2'sd0);
    mv_h = (dh != 2'sd0) && (!both || !ptr_v);
    mv_v = (dv != 2'sd0) && (!both || ptr_v);
  end

  always_ff @(posedge clk_148MHz or posedge reset) begin
    if (reset)                 ptr_v <= 1'b0;
    else if (run_tick && both) ptr_v <= ~ptr_v;
  end
`endif

  always_comb begin
    logic signed [12:0] sstep;
    sstep = signed'({10'd0, step_cur});
    nxt_h = pos_h;
    nxt_v = pos_v;
    if (mv_h)
      nxt_h = clamp_pos(signed'({1'b0, pos_h}) + (dh[1] ? -sstep : sstep), LO, HI_H);
    if (mv_v)
      nxt_v = clamp_pos(signed'({1'b0, pos_v}) + (dv[1] ? -sstep : sstep), LO, HI_V);
  end

  // ---------------- FSM + position ----------------
  always_ff @(posedge clk_148MHz or posedge reset) begin
    if (reset) begin
      st    <= ST_IDLE;
      pos_h <= RST_H;
      pos_v <= RST_V;
      rc    <= '0;
    end else if (!enable) begin
      st <= ST_IDLE;
      rc <= '0;
    end else begin
      case (st)
        ST_IDLE: st <= ST_RUN;
        ST_RUN: begin
          if (frame_tick) begin
            if (collision) begin
              // collision beats any pending step on this frame
              pos_h <= RST_H;
              pos_v <= RST_V;
              rc    <= RCW'(RECENTER_FRAMES);
              st    <= ST_RECENTER;
            end else begin
              pos_h <= nxt_h;
              pos_v <= nxt_v;
            end
          end
        end
        ST_RECENTER: begin
          if (frame_tick) begin
            if (rc <= RCW'(1)) begin
              rc <= '0;
              st <= ST_RUN;
            end else begin
              rc <= rc - 1'b1;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motion_scheduler.sv
// tb_motion_scheduler -- randomized + directed bench for motion_scheduler,
// checked against a frame-level behavioural model of the circle motion.
module tb_motion_scheduler;

  localparam int DEB  = 8;
  localparam int RAMP = 30;
  localparam int MAXS = 4;
  localparam int RF   = 60;
  localparam int HD   = 1920;
  localparam int VD   = 1080;
  localparam int R    = 100;

  logic        clk_148MHz = 1'b0;
  logic        reset, enable, btnU, btnD, btnL, btnR, frame_tick, collision;
  logic [11:0] pos_h, pos_v;
  logic [2:0]  step;
  logic        moving, frozen;

  always #3 clk_148MHz = ~clk_148MHz;

  motion_scheduler #(
    .DEB_CYCLES(DEB), .RAMP_FRAMES(RAMP), .MAX_STEP(MAXS), .RECENTER_FRAMES(RF)
  ) dut (
    .clk_148MHz(clk_148MHz), .reset(reset), .enable(enable),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .frame_tick(frame_tick), .collision(collision),
    .pos_h(pos_h), .pos_v(pos_v), .step(step), .moving(moving), .frozen(frozen)
  );

  int errs = 0;
  int nchk = 0;

  // model: st 0=IDLE 1=RUN 2=RECENTER; btn bits {U,D,L,R}
  int       m_h, m_v, m_hold, m_rc, m_st;
  bit       m_ptr;
  bit [3:0] m_btn;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mdh();
    return (m_btn[1] && !m_btn[0]) ? -1 : (m_btn[0] && !m_btn[1]) ? 1 : 0;
  endfunction
  function automatic int mdv();
    return (m_btn[3] && !m_btn[2]) ? -1 : (m_btn[2] && !m_btn[3]) ? 1 : 0;
  endfunction
  function automatic int spd(input int h);
    return (h < RAMP) ? 1 : (h < 2 * RAMP) ? 2 : MAXS;
  endfunction
  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic check_all(input string tag);
    bit mv;
    mv = (m_st == 1) && (mdh() != 0 || mdv() != 0);
    chk({tag, ".pos_h"},  pos_h,  m_h);
    chk({tag, ".pos_v"},  pos_v,  m_v);
    chk({tag, ".frozen"}, frozen, int'(m_st == 2));
    chk({tag, ".moving"}, moving, int'(mv));
    chk({tag, ".step"},   step,   mv ? spd(m_hold) : 0);
  endtask

  task automatic tick(input bit col, input string tag);
    int  dh, dv, s;
    bit  mh, mvv;
    @(negedge clk_148MHz);
    frame_tick = 1'b1;
    collision  = col;
    @(negedge clk_148MHz);
    frame_tick = 1'b0;
    collision  = 1'b0;
    dh = mdh();
    dv = mdv();
    if (m_st == 1) begin
      if (col) begin
        m_h = HD / 2; m_v = VD / 2; m_rc = RF; m_st = 2; m_hold = 0;
      end else if (dh != 0 || dv != 0) begin
        s   = spd(m_hold);
        mh  = (dh != 0);
        mvv = (dv != 0);
`ifndef MOTION_DIAG_EN
        if (mh && mvv) begin
          if (m_ptr) mh = 1'b0; else mvv = 1'b0;
          m_ptr = !m_ptr;
        end
`endif
        if (mh)  m_h = clampi(m_h + dh * s, R + 1, HD - R - 1);
        if (mvv) m_v = clampi(m_v + dv * s, R + 1, VD - R - 1);
        m_hold++;
      end
    end else if (m_st == 2) begin
      m_rc--;
      if (m_rc == 0) m_st = 1;
    end
    check_all(tag);
  endtask

  task automatic set_btns(input bit [3:0] b);
    int odh, odv;
    odh = mdh();
    odv = mdv();
    @(negedge clk_148MHz);
    {btnU, btnD, btnL, btnR} = b;
    repeat (DEB + 6) @(negedge clk_148MHz);
    m_btn = b;
    if (mdh() != odh || mdv() != odv) m_hold = 0;
    check_all("btn");
  endtask

  // flip one raw button for fewer than DEB samples: must be filtered out
  task automatic glitch(input int idx, input int len);
    bit [3:0] b;
    b = m_btn;
    b[idx] = !b[idx];
    @(negedge clk_148MHz);
    {btnU, btnD, btnL, btnR} = b;
    repeat (len) @(negedge clk_148MHz);
    {btnU, btnD, btnL, btnR} = m_btn;
    repeat (DEB + 6) @(negedge clk_148MHz);
    check_all("glitch");
  endtask

  task automatic set_en(input bit e);
    @(negedge clk_148MHz);
    enable = e;
    repeat (3) @(negedge clk_148MHz);
    if (!e) begin
      m_st = 0; m_hold = 0; m_rc = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end
    check_all("en");
  endtask

  task automatic model_reset();
    m_h = HD / 2; m_v = VD / 2; m_hold = 0; m_rc = 0; m_st = 0;
    m_ptr = 1'b0; m_btn = '0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; frame_tick = 1'b0; collision = 1'b0;
    {btnU, btnD, btnL, btnR} = 4'b0000;
    model_reset();
    repeat (3) @(negedge clk_148MHz);
    check_all("reset");
    reset = 1'b0;
    set_en(1'b1);

    // single axis, slow tier, then a filtered glitch
    set_btns(4'b0001);
    repeat (5) tick(1'b0, "r5");
    glitch(1, DEB - 1);
    tick(1'b0, "post_glitch");

    // opposing buttons cancel
    set_btns(4'b0011);
    tick(1'b0, "lr");

    // two axes requested
    set_btns(4'b1001);
    repeat (3) tick(1'b0, "ru");

    // speed ramp then right clamp
    set_btns(4'b0001);
    repeat (2 * RAMP + 2) tick(1'b0, "ramp");
    repeat (200) tick(1'b0, "clamp_r");

    // collision with D held, recenter window, resume
    set_btns(4'b0100);
    tick(1'b1, "coll");
    repeat (RF) tick(1'b0, "frz");
    tick(1'b0, "resume");

    // reset in the middle of RECENTER
    tick(1'b1, "coll2");
    repeat (5) tick(1'b0, "frz2");
    set_btns(4'b0000);
    @(negedge clk_148MHz);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk_148MHz);
    check_all("rst_hold");
    reset = 1'b0;
    repeat (2) @(negedge clk_148MHz);
    m_st = 1;
    check_all("rst_rel");

    // random phase
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: tick($urandom_range(0, 11) == 0, "rnd_tick");
        5, 6:          set_btns(4'($urandom_range(0, 15)));
        7:             glitch($urandom_range(0, 3), $urandom_range(1, DEB - 1));
        8: begin
          if (!enable) set_en(1'b1);
          else if ($urandom_range(0, 2) == 0) set_en(1'b0);
        end
        default: begin
          int n;
          n = $urandom_range(5, 20);
          repeat (n) tick(1'b0, "rnd_burst");
        end
      endcase
    end

    // remaining clamp edges
    if (!enable) set_en(1'b1);
    repeat (RF + 1) tick(1'b0, "drain");
    set_btns(4'b0010);
    repeat (280) tick(1'b0, "clamp_l");
    set_btns(4'b1000);
    repeat (200) tick(1'b0, "clamp_u");
    set_btns(4'b0100);
    repeat (250) tick(1'b0, "clamp_d");

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
